moore_11011_seq_gen: RTL

//   Moore-style serial pattern generator: the transmit end of the 11011 detector path.
//   On a start request it emits PATTERN MSB-first, one bit per clk, repeat_n times.
//   An optional idle gap separates repetitions; the sequence can be paused with stall.

---
 rtl/moore_11011_seq_gen_if.sv | 24 ++
 rtl/moore_11011_seq_gen.sv | 126 ++++++++++++
 2 files changed

// File: rtl/moore_11011_seq_gen_if.sv
// Handshake bundle for the serial pattern generator: job request in, serial bit stream and status out.
interface moore_11011_seq_gen_if #(
   parameter int CNT_W = 4
);
   logic             start;
   logic [CNT_W-1:0] repeat_n;
   logic             stall;
   logic             out;
   logic             out_valid;
   logic             busy;
   logic             done;

   // Requester side: issues jobs and consumes the bit stream.
   modport master (
      output start, repeat_n, stall,
      input  out, out_valid, busy, done
   );

   // Generator side.
   modport slave (
      input  start, repeat_n, stall,
      output out, out_valid, busy, done
   );
endinterface

// File: rtl/moore_11011_seq_gen.sv
// Moore serial pattern generator: sends PATTERN MSB-first repeat_n times,
// with GAP_CYC idle cycles between repetitions, pausable with stall.
//
// state | meaning
// IDLE  | waiting for start; outputs all 0
// SEND  | driving one pattern bit per cycle, out_valid=1
// GAP   | idle spacing between repetitions, out_valid=0
// DONE  | one-cycle done pulse, then back to IDLE
module moore_11011_seq_gen #(
   parameter int               PAT_W   = 5,
   parameter logic [PAT_W-1:0] PATTERN = 5'b11011,
   parameter int               CNT_W   = 4,
   parameter int               GAP_CYC = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   moore_11011_seq_gen_if.slave  bus
);
   localparam int BIT_W = (PAT_W > 1) ? $clog2(PAT_W) : 1;
   localparam int GAP_W = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
   localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(PAT_W - 1);
   // GAP is unreachable when GAP_CYC==0, so the clamp only keeps the constant legal.
   localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);

   typedef enum logic [1:0] {IDLE, SEND, GAP, DONE} state_t;

   state_t           state;
   logic [PAT_W-1:0] shreg;
   logic [BIT_W-1:0] bitcnt;
   logic [GAP_W-1:0] gapcnt;
   logic [CNT_W-1:0] repcnt;
   logic             out_r;
   logic             valid_r;
   logic             busy_r;
   logic             done_r;

   // Outputs are registered alongside the state, so they always reflect the state just entered.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= IDLE;
         shreg   <= '0;
         bitcnt  <= '0;
         gapcnt  <= '0;
         repcnt  <= '0;
         out_r   <= 1'b0;
         valid_r <= 1'b0;
         busy_r  <= 1'b0;
         done_r  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.start) begin
                  busy_r <= 1'b1;
                  if (bus.repeat_n != '0) begin
                     state   <= SEND;
                     shreg   <= PATTERN;
                     repcnt  <= bus.repeat_n;
                     bitcnt  <= '0;
                     out_r   <= PATTERN[PAT_W-1];
                     valid_r <= 1'b1;
                  end else begin
                     state  <= DONE;
                     done_r <= 1'b1;
                  end
               end
            end
            SEND: begin
               if (!bus.stall) begin
                  if (bitcnt == BIT_LAST) begin
                     repcnt <= repcnt - CNT_W'(1);
                     if (repcnt == CNT_W'(1)) begin
                        state   <= DONE;
                        out_r   <= 1'b0;
                        valid_r <= 1'b0;
                        done_r  <= 1'b1;
                     end else if (GAP_CYC == 0) begin
                        shreg  <= PATTERN;
                        bitcnt <= '0;
                        out_r  <= PATTERN[PAT_W-1];
                     end else begin
                        state   <= GAP;
                        gapcnt  <= '0;
                        out_r   <= 1'b0;
                        valid_r <= 1'b0;
                     end
                  end else begin
                     shreg  <= {shreg[PAT_W-2:0], 1'b0};
                     bitcnt <= bitcnt + BIT_W'(1);
                     out_r  <= shreg[PAT_W-2];
                  end
               end
            end
            GAP: begin
               if (!bus.stall) begin
                  if (gapcnt == GAP_LAST) begin
                     state   <= SEND;
                     shreg   <= PATTERN;
                     bitcnt  <= '0;
                     out_r   <= PATTERN[PAT_W-1];
                     valid_r <= 1'b1;
                  end else begin
                     gapcnt <= gapcnt + GAP_W'(1);
                  end
               end
            end
            DONE: begin
               state  <= IDLE;
               busy_r <= 1'b0;
               done_r <= 1'b0;
            end
            default: begin
               state   <= IDLE;
               out_r   <= 1'b0;
               valid_r <= 1'b0;
               busy_r  <= 1'b0;
               done_r  <= 1'b0;
            end
         endcase
      end
   end

   assign bus.out       = out_r;
   assign bus.out_valid = valid_r;
   assign bus.busy      = busy_r;
   assign bus.done      = done_r;
endmodule
